// File: rtl/div_unit.sv
// Multi-cycle restoring divider: signed/unsigned quotient and remainder,
// one quotient bit per cycle behind a start/busy/done handshake.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CNT_W = 6;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]       state, next_state;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;

  logic             accept, is_zero, is_ovf, special, q_bit, last_iter;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   r_shift, r_diff;

  // Accept decode, operand magnitudes and one restoring iteration
  always_comb begin
    accept    = start && (state == IDLE);
    is_zero   = (b == '0);
    is_ovf    = sign && (a == MIN_NEG) && (b == ALL_ONES);
    special   = is_zero || is_ovf;
    abs_a     = (sign && a[WIDTH-1]) ? -a : a;
    abs_b     = (sign && b[WIDTH-1]) ? -b : b;
    r_shift   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    r_diff    = r_shift - {1'b0, dvs_q};
    q_bit     = (r_shift >= {1'b0, dvs_q});
    last_iter = (cnt == CNT_W'(WIDTH-1));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !special) next_state = CALC;
      CALC:    if (last_iter) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Datapath and result registers; special cases write results on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_zero) begin
              quotient    <= ALL_ONES;
              remainder   <= a;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              done        <= 1'b1;
            end else if (is_ovf) begin
              quotient    <= MIN_NEG;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              done        <= 1'b1;
            end else begin
              dvd_q <= abs_a;
              dvs_q <= abs_b;
              neg_q <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= sign && a[WIDTH-1];
              rem_q <= '0;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          rem_q <= q_bit ? r_diff : r_shift;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          cnt   <= cnt + CNT_W'(1);
        end
        FIX: begin
          quotient    <= neg_q ? -dvd_q : dvd_q;
          remainder   <= neg_r ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
